// File: rtl/mod_32bit.sv
// Sequential unsigned modulus unit: computes a mod b by restoring shift-subtract,
// one iteration per clock, with a start/done handshake and divide-by-zero flag.
module mod_32bit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] d_r;
   logic [WIDTH-1:0] r_r;
   logic [5:0]       cnt_r;
   logic [WIDTH:0]   t_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] r_next_s;
   logic             ge_s;
   logic             last_s;
   logic             b_zero_s;

   // Iteration datapath: shift in next dividend bit, compare and conditionally subtract.
   // The compare is WIDTH+1 wide so the shifted remainder never wraps; the restored
   // remainder is always below d, so only its low WIDTH bits need to be kept.
   always_comb begin
      t_s      = {r_r, q_r[WIDTH-1]};
      ge_s     = (t_s >= {1'b0, d_r});
      diff_s   = t_s[WIDTH-1:0] - d_r;
      r_next_s = t_s[WIDTH-1:0];
      if (ge_s) begin
         r_next_s = diff_s;
      end else begin
         r_next_s = t_s[WIDTH-1:0];
      end
      last_s   = (cnt_r == 6'(WIDTH - 1));
      b_zero_s = (b == {WIDTH{1'b0}});
   end

   // Next-state decode for the IDLE/RUN/DONE controller.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (b_zero_s) begin
                  state_s = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         q_r      <= {WIDTH{1'b0}};
         d_r      <= {WIDTH{1'b0}};
         r_r      <= {WIDTH{1'b0}};
         cnt_r    <= 6'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= {WIDTH{1'b0}};
         div_zero <= 1'b0;
      end else begin
         state_r <= state_s;
         busy    <= (state_s != IDLE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  if (b_zero_s) begin
                     result   <= a;
                     div_zero <= 1'b1;
                     done     <= 1'b1;
                  end else begin
                     q_r      <= a;
                     d_r      <= b;
                     r_r      <= {WIDTH{1'b0}};
                     cnt_r    <= 6'd0;
                     div_zero <= 1'b0;
                     done     <= 1'b0;
                  end
               end else begin
                  done <= 1'b0;
               end
            end
            RUN: begin
               q_r   <= q_r << 1;
               r_r   <= r_next_s;
               cnt_r <= cnt_r + 6'd1;
               done  <= last_s;
               if (last_s) begin
                  result <= r_next_s;
               end else begin
                  result <= result;
               end
            end
            DONE:    done <= 1'b0;
            default: done <= 1'b0;
         endcase
      end
   end

endmodule
